// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line ports seen by mem_arbiter.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) ();
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp, pmem_read, pmem_write,
           pmem_address, pmem_wdata
  );

  modport master (
    output icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp, pmem_read, pmem_write,
           pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single physical-memory line port between I-cache and D-cache,
// one line transaction at a time, with all outputs registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LINE_W          = 256,
  parameter int unsigned DCACHE_PRIORITY = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_d_q, last_grant_d_d;  // 1: last grant went to the D-cache
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [LINE_W-1:0] icache_rdata_q, icache_rdata_d;
  logic [LINE_W-1:0] dcache_rdata_q, dcache_rdata_d;
  logic              icache_resp_q, icache_resp_d;
  logic              dcache_resp_q, dcache_resp_d;

  logic i_req, d_req, d_wins;

  assign i_req  = bus.icache_read;
  assign d_req  = bus.dcache_read | bus.dcache_write;
  // On a tie, round-robin hands the grant to whoever did not get the previous one.
  assign d_wins = d_req & (~i_req | (DCACHE_PRIORITY != 0) | ~last_grant_d_q);

  always_comb begin
    state_d        = state_q;
    last_grant_d_d = last_grant_d_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    icache_rdata_d = icache_rdata_q;
    dcache_rdata_d = dcache_rdata_q;
    icache_resp_d  = 1'b0;
    dcache_resp_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_wins) begin
          state_d        = StBusyD;
          last_grant_d_d = 1'b1;
          pmem_address_d = bus.dcache_address;
          pmem_wdata_d   = bus.dcache_wdata;
          // Read and write together is treated as a writeback.
          pmem_write_d   = bus.dcache_write;
          pmem_read_d    = ~bus.dcache_write;
        end else if (i_req) begin
          state_d        = StBusyI;
          last_grant_d_d = 1'b0;
          pmem_address_d = bus.icache_address;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
        end
      end
      StBusyI: begin
        if (bus.pmem_resp) begin
          state_d        = StResp;
          icache_rdata_d = bus.pmem_rdata;
          icache_resp_d  = 1'b1;
          pmem_read_d    = 1'b0;
          pmem_write_d   = 1'b0;
        end
      end
      StBusyD: begin
        if (bus.pmem_resp) begin
          state_d        = StResp;
          dcache_rdata_d = bus.pmem_rdata;
          dcache_resp_d  = 1'b1;
          pmem_read_d    = 1'b0;
          pmem_write_d   = 1'b0;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      last_grant_d_q <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      icache_rdata_q <= '0;
      dcache_rdata_q <= '0;
      icache_resp_q  <= 1'b0;
      dcache_resp_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_d_q <= last_grant_d_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      icache_rdata_q <= icache_rdata_d;
      dcache_rdata_q <= dcache_rdata_d;
      icache_resp_q  <= icache_resp_d;
      dcache_resp_q  <= dcache_resp_d;
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.icache_rdata = icache_rdata_q;
  assign bus.dcache_rdata = dcache_rdata_q;
  assign bus.icache_resp  = icache_resp_q;
  assign bus.dcache_resp  = dcache_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a D-priority instance for most scenarios and a
// round-robin instance for the alternating-grant scenario.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus1 ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus0 ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DCACHE_PRIORITY(1)) dut_p1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DCACHE_PRIORITY(0)) dut_p0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the pmem op on bus1, check it, answer after lat cycles, check the response.
  task automatic serve1(input string tag, input bit is_i, input bit is_wr,
                        input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                        input logic [LINE_W-1:0] rdata, input int lat);
    int n = 0;
    while (!(bus1.pmem_read || bus1.pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_granted"}, n < 20, 1'b1);
    check({tag, "_rd"}, bus1.pmem_read, !is_wr);
    check({tag, "_wr"}, bus1.pmem_write, is_wr);
    check({tag, "_addr"}, bus1.pmem_address, addr);
    if (is_wr) check({tag, "_wdata"}, bus1.pmem_wdata, wdata);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_addr_hold"}, bus1.pmem_address, addr);
      check({tag, "_op_hold"}, bus1.pmem_read | bus1.pmem_write, 1'b1);
    end
    bus1.pmem_resp  = 1'b1;
    bus1.pmem_rdata = rdata;
    @(negedge clk);
    bus1.pmem_resp  = 1'b0;
    check({tag, "_iresp"}, bus1.icache_resp, is_i);
    check({tag, "_dresp"}, bus1.dcache_resp, !is_i);
    if (is_i) check({tag, "_irdata"}, bus1.icache_rdata, rdata);
    else      check({tag, "_drdata"}, bus1.dcache_rdata, rdata);
    check({tag, "_op_drop"}, bus1.pmem_read | bus1.pmem_write, 1'b0);
    if (is_i) bus1.icache_read = 1'b0;
    else begin
      bus1.dcache_read  = 1'b0;
      bus1.dcache_write = 1'b0;
    end
    @(negedge clk);
    check({tag, "_resp_once"}, bus1.icache_resp | bus1.dcache_resp, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LINE_W-1:0] a5, wdat, r1, r2, r3, r4, r5;
    a5   = {32{8'hA5}};
    wdat = {8{32'h1234_5678}};
    r1   = {8{32'hD00D_0001}};
    r2   = {8{32'h1CE0_0002}};
    r3   = {8{32'h3333_CCCC}};
    r4   = {8{32'h4444_0004}};
    r5   = {8{32'h5555_0005}};

    bus1.icache_read = 0; bus1.icache_address = '0; bus1.dcache_read = 0;
    bus1.dcache_write = 0; bus1.dcache_address = '0; bus1.dcache_wdata = '0;
    bus1.pmem_rdata = '0; bus1.pmem_resp = 0;
    bus0.icache_read = 0; bus0.icache_address = '0; bus0.dcache_read = 0;
    bus0.dcache_write = 0; bus0.dcache_address = '0; bus0.dcache_wdata = '0;
    bus0.pmem_rdata = '0; bus0.pmem_resp = 0;

    repeat (2) @(negedge clk);
    check("rst_rd", bus1.pmem_read, 1'b0);
    check("rst_wr", bus1.pmem_write, 1'b0);
    check("rst_addr", bus1.pmem_address, '0);
    check("rst_wdata", bus1.pmem_wdata, '0);
    check("rst_resp", {bus1.icache_resp, bus1.dcache_resp}, 2'b00);
    check("rst_irdata", bus1.icache_rdata, '0);
    check("rst_drdata", bus1.dcache_rdata, '0);
    rst = 1'b1;

    // Lone I read.
    @(negedge clk);
    bus1.icache_read = 1; bus1.icache_address = 32'h0000_0040;
    serve1("lone_i", 1, 0, 32'h40, '0, a5, 0);
    check("lone_i_rdata_hold", bus1.icache_rdata, a5);

    // Tie with D priority: D write first, then I read.
    bus1.icache_read = 1; bus1.icache_address = 32'h100;
    bus1.dcache_write = 1; bus1.dcache_address = 32'h200; bus1.dcache_wdata = wdat;
    serve1("tie_d", 0, 1, 32'h200, wdat, r1, 1);
    serve1("tie_i", 1, 0, 32'h100, '0, r2, 0);

    // Read and write together act as a write.
    bus1.dcache_read = 1; bus1.dcache_write = 1; bus1.dcache_address = 32'h300;
    bus1.dcache_wdata = ~wdat;
    serve1("rdwr", 0, 1, 32'h300, ~wdat, r1, 0);

    // Winner changes its address while the transaction is in flight.
    bus1.icache_read = 1; bus1.icache_address = 32'h80;
    @(negedge clk);
    bus1.icache_address = 32'hDEAD_BEE0;
    serve1("midbusy", 1, 0, 32'h80, '0, r3, 3);

    // Async reset while a D writeback is in flight.
    bus1.dcache_write = 1; bus1.dcache_address = 32'h400; bus1.dcache_wdata = wdat;
    @(negedge clk);
    check("rstmid_wr_before", bus1.pmem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_wr", bus1.pmem_write, 1'b0);
    check("rstmid_rd", bus1.pmem_read, 1'b0);
    check("rstmid_addr", bus1.pmem_address, '0);
    check("rstmid_wdata", bus1.pmem_wdata, '0);
    check("rstmid_irdata", bus1.icache_rdata, '0);
    bus1.dcache_write = 0;
    bus1.pmem_resp = 1;
    @(negedge clk);
    bus1.pmem_resp = 0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_no_resp", {bus1.icache_resp, bus1.dcache_resp}, 2'b00);
    bus1.icache_read = 1; bus1.icache_address = 32'h500;
    serve1("post_rst", 1, 0, 32'h500, '0, r4, 0);

    // Stray pmem_resp while idle.
    bus1.pmem_resp = 1; bus1.pmem_rdata = r5;
    @(negedge clk);
    bus1.pmem_resp = 0;
    check("stray_resp", {bus1.icache_resp, bus1.dcache_resp}, 2'b00);
    check("stray_op", {bus1.pmem_read, bus1.pmem_write}, 2'b00);
    check("stray_irdata", bus1.icache_rdata, r4);
    @(negedge clk);
    check("stray_resp2", {bus1.icache_resp, bus1.dcache_resp}, 2'b00);
    check("stray_op2", {bus1.pmem_read, bus1.pmem_write}, 2'b00);

    // Round-robin instance: both requesters keep re-requesting, grants go D,I,D,I.
    bus0.icache_address = 32'h600; bus0.dcache_address = 32'h700;
    bus0.icache_read = 1; bus0.dcache_read = 1;
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
      int n;
      exp_d = (k % 2 == 0);
      n = 0;
      while (!bus0.pmem_read && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rr%0d_granted", k), n < 20, 1'b1);
      check($sformatf("rr%0d_addr", k), bus0.pmem_address, exp_d ? 32'h700 : 32'h600);
      bus0.pmem_resp = 1; bus0.pmem_rdata = {LINE_W{1'b0}} | k;
      @(negedge clk);
      bus0.pmem_resp = 0;
      check($sformatf("rr%0d_dresp", k), bus0.dcache_resp, exp_d);
      check($sformatf("rr%0d_iresp", k), bus0.icache_resp, !exp_d);
      if (exp_d) bus0.dcache_read = 0;
      else       bus0.icache_read = 0;
      @(negedge clk);
      bus0.dcache_read = 1; bus0.icache_read = 1;
    end
    bus0.dcache_read = 0; bus0.icache_read = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
